// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS field positions, extension opcodes and decoded-field struct
package mips_isa_pkg;
  localparam int OPC_MSB   = 31;
  localparam int RS_MSB    = 25;
  localparam int RT_MSB    = 20;
  localparam int RD_MSB    = 15;
  localparam int SHAMT_MSB = 10;
  localparam int FUNCT_MSB = 5;
  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI  = 6'h0D;
  localparam logic [5:0] OPC_XORI = 6'h0E;
  localparam logic [5:0] OPC_LUI  = 6'h0F;
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_fields_t;
endpackage

// File: rtl/instr_field_split.sv
// instr_field_split: combinational MIPS word split with opcode-selected immediate extension
module instr_field_split
  import mips_isa_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     word_i,
  output instr_fields_t   fields_o,
  output logic [XLEN-1:0] imm_o
);
  logic [5:0] opc;
  logic       zext;
  assign opc  = word_i[OPC_MSB -: 6];
  assign zext = opc inside {OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI};
  always_comb begin
    fields_o.opcode = opc;
    fields_o.rs     = word_i[RS_MSB -: 5];
    fields_o.rt     = word_i[RT_MSB -: 5];
    fields_o.rd     = word_i[RD_MSB -: 5];
    fields_o.shamt  = word_i[SHAMT_MSB -: 5];
    fields_o.funct  = word_i[FUNCT_MSB -: 6];
  end
  assign imm_o = zext ? XLEN'(word_i[15:0]) : XLEN'($signed(word_i[15:0]));
endmodule

// File: rtl/instr_field_decode_stage.sv
// instr_field_decode_stage: 2-entry skid FIFO between fetch and decode, fields split from the registered head
module instr_field_decode_stage
  import mips_isa_pkg::*;
#(
  parameter int                 INSTR_W  = 32,
  parameter int                 XLEN     = 32,
  parameter int                 PC_W     = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] in_instr_i,
  input  logic [PC_W-1:0]    in_pc_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [PC_W-1:0]    out_pc_o,
  output logic [5:0]         out_opcode_o,
  output logic [4:0]         out_rs_o,
  output logic [4:0]         out_rt_o,
  output logic [4:0]         out_rd_o,
  output logic [4:0]         out_shamt_o,
  output logic [5:0]         out_funct_o,
  output logic [XLEN-1:0]    out_imm_o,
  output logic [1:0]         out_count_o
);
  logic [INSTR_W-1:0] instr_q [2];
  logic [PC_W-1:0]    pc_q [2];
  logic               head_q, head_d, tail_q, tail_d;
  logic [1:0]         count_q, count_d;
  logic               push, pop;
  instr_fields_t      fields;
  assign in_ready_o  = !reset_i && count_q != 2'd2;
  assign out_valid_o = count_q != 2'd0;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  always_comb begin
    count_d = flush_i ? 2'd0 : count_q + 2'(push) - 2'(pop);
    head_d  = flush_i ? 1'b0 : head_q ^ pop;
    tail_d  = flush_i ? 1'b0 : tail_q ^ push;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
  // payload needs no reset: it is only visible while count_q marks it valid
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      instr_q[tail_q] <= in_instr_i;
      pc_q[tail_q]    <= in_pc_i;
    end
  end
  assign out_instr_o = out_valid_o ? instr_q[head_q] : NOP_WORD;
  assign out_pc_o    = out_valid_o ? pc_q[head_q] : '0;
  assign out_count_o = count_q;
  instr_field_split #(.XLEN(XLEN)) u_split (
    .word_i  (out_instr_o[31:0]),
    .fields_o(fields),
    .imm_o   (out_imm_o)
  );
  assign out_opcode_o = fields.opcode;
  assign out_rs_o     = fields.rs;
  assign out_rt_o     = fields.rt;
  assign out_rd_o     = fields.rd;
  assign out_shamt_o  = fields.shamt;
  assign out_funct_o  = fields.funct;
endmodule
